// File: rtl/unibus_map_arb_pkg.sv
// unibus_map_arb_pkg: shared types, field widths and helpers for the Unibus map / DMA arbiter.
// Rev 1.0
`default_nettype none

package unibus_map_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OWN  = 2'd2
  } arb_state_t;

  localparam int          L_W         = 7;
  localparam int          M_W         = 8;
  localparam int          PAGE_LSB    = 13;
  localparam logic [4:0]  IOPAGE_TAG  = 5'b11111;
  localparam logic [21:0] UM_BASE_DEF = 22'o17770200;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/unibus_map_arb_rr.sv
// rr_arbiter: round-robin pick of the first requester at/after the pointer; pointer advances on release.
// Rev 1.0
`default_nettype none

module rr_arbiter
  import unibus_map_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int SW  = idx_width(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] i_req,
  input  logic           i_release,
  input  logic [SW-1:0]  i_rel_idx,
  output logic [SW-1:0]  o_sel,
  output logic           o_any
);

  logic [SW-1:0]    r_ptr;
  logic [2*NCH-1:0] w_dbl;
  logic [NCH-1:0]   w_rot;

  // Rotate so bit 0 is the pointer position; scan downward so the lowest offset wins.
  assign w_dbl = {i_req, i_req} >> r_ptr;
  assign w_rot = w_dbl[NCH-1:0];

  always_comb begin
    o_sel = r_ptr;
    o_any = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_sel = SW'((int'(r_ptr) + k) % NCH);
        o_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_release) begin
      r_ptr <= (int'(i_rel_idx) == NCH - 1) ? '0 : i_rel_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/unibus_map_arb.sv
// unibus_map_arb: DMA round-robin arbitration, CPU hold-off and 18-bit Unibus to PA-bit address mapping.
// Rev 1.0
`default_nettype none

module unibus_map_arb
  import unibus_map_arb_pkg::*;
#(
  parameter int          NCH        = 2,
  parameter int          NREG       = 32,
  parameter int          PA         = 22,
  parameter logic [21:0] UM_BASE    = UM_BASE_DEF,
  parameter bit          IOPAGE_MAP = 1'b0
) (
  input  logic            clk_p,
  input  logic            dclo,
  input  logic            um_enable,
  input  logic            cpu_stb,
  output logic            cpu_hold,
  input  logic [PA-1:0]   wb_adr_i,
  input  logic [15:0]     wb_dat_i,
  output logic [15:0]     wb_dat_o,
  input  logic            wb_we_i,
  input  logic [1:0]      wb_sel_i,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  input  logic [NCH-1:0]  dma_req,
  output logic [NCH-1:0]  dma_gnt,
  input  logic [NCH*18-1:0] dma_adr18,
  input  logic [NCH-1:0]  dma_stb,
  output logic [PA-1:0]   mem_adr,
  output logic            mem_stb
);

  localparam int SW = idx_width(NCH);
  localparam int RW = idx_width(NREG);
  localparam int HW = PA - 16;

  logic [L_W-1:0] r_l [NREG];
  logic [M_W-1:0] r_m [NREG];
  logic [HW-1:0]  r_h [NREG];

  arb_state_t     r_state;
  logic [SW-1:0]  r_sel;
  logic           r_hold;
  logic [NCH-1:0] r_gnt;
  logic [PA-1:0]  r_mem_adr;
  logic           r_mem_stb;
  logic           r_ack;
  logic [15:0]    r_dat;

  // ---------------- register window decode ----------------
  logic [21:0]   w_abs;
  logic [21:0]   w_off;
  logic          w_dec;
  logic          w_hi;
  logic [RW-1:0] w_widx;
  logic [15:0]   w_rd;

  assign w_abs  = 22'(wb_adr_i);
  assign w_off  = w_abs - UM_BASE;
  assign w_dec  = wb_stb_i && (w_abs >= UM_BASE) && (w_off < 22'(NREG * 4));
  assign w_hi   = w_off[1];
  assign w_widx = (NREG == 1) ? '0 : w_off[RW+1:2];
  assign w_rd   = w_hi ? 16'(r_h[w_widx]) : {r_m[w_widx], r_l[w_widx], 1'b0};

  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo) begin
      for (int i = 0; i < NREG; i++) begin
        r_l[i] <= '0;
        r_m[i] <= '0;
        r_h[i] <= '0;
      end
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_dec;
      r_dat <= w_dec ? w_rd : '0;
      // First cycle of a strobe only, so a long strobe writes once.
      if (w_dec && wb_we_i && !r_ack) begin
        if (w_hi) begin
          if (wb_sel_i[0]) r_h[w_widx] <= wb_dat_i[HW-1:0];
        end else begin
          if (wb_sel_i[0]) r_l[w_widx] <= wb_dat_i[7:1];
          if (wb_sel_i[1]) r_m[w_widx] <= wb_dat_i[15:8];
        end
      end
    end
  end

  // ---------------- translation ----------------
  logic [17:0]   w_ch_adr [NCH];
  logic [17:0]   w_adr;
  logic [RW-1:0] w_tidx;
  logic [PA-1:0] w_base;
  logic [PA-1:0] w_xlat;
  logic          w_req_sel;
  logic          w_stb_sel;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign w_ch_adr[g] = dma_adr18[18*g +: 18];
  end

  assign w_adr     = w_ch_adr[r_sel];
  assign w_req_sel = dma_req[r_sel];
  assign w_stb_sel = dma_stb[r_sel];
  assign w_tidx    = (NREG == 1) ? '0 : RW'(w_adr[17:PAGE_LSB]);
  assign w_base    = {r_h[w_tidx], r_m[w_tidx], r_l[w_tidx], 1'b0};

  always_comb begin
    w_xlat = PA'(w_adr);
    if (IOPAGE_MAP && (w_adr[17:PAGE_LSB] == IOPAGE_TAG)) begin
      w_xlat = {{(PA-PAGE_LSB){1'b1}}, w_adr[PAGE_LSB-1:0]};
    end else if (um_enable) begin
      w_xlat = w_base + PA'(w_adr[PAGE_LSB-1:0]);
    end
  end

  // ---------------- arbiter FSM ----------------
  logic [SW-1:0] w_pick;
  logic          w_any;
  logic          w_release;

  assign w_release = (r_state == ST_OWN) && !w_req_sel && !w_stb_sel;

  rr_arbiter #(.NCH(NCH), .SW(SW)) u_rr (
    .clk       (clk_p),
    .rst       (dclo),
    .i_req     (dma_req),
    .i_release (w_release),
    .i_rel_idx (r_sel),
    .o_sel     (w_pick),
    .o_any     (w_any)
  );

  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_hold    <= 1'b0;
      r_gnt     <= '0;
      r_mem_adr <= '0;
      r_mem_stb <= 1'b0;
    end else begin
      r_mem_stb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_sel   <= w_pick;
            r_hold  <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!w_req_sel) begin
            r_hold  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (!cpu_stb) begin
            r_gnt   <= NCH'(1) << r_sel;
            r_state <= ST_OWN;
          end
        end
        ST_OWN: begin
          r_mem_adr <= w_xlat;
          r_mem_stb <= w_stb_sel;
          if (w_release) begin
            r_gnt   <= '0;
            r_hold  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_hold = r_hold;
  assign dma_gnt  = r_gnt;
  assign mem_adr  = r_mem_adr;
  assign mem_stb  = r_mem_stb;
  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;

endmodule

`default_nettype wire
